// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi input path: channel indices, event code
// layout and the per-button state encoding.
package tamagotchi_pkg;

  localparam int unsigned CH_HEAL  = 0;
  localparam int unsigned CH_ALI   = 1;
  localparam int unsigned CH_RST   = 2;
  localparam int unsigned CH_TST   = 3;
  localparam int unsigned CH_ULTRA = 4;
  localparam int unsigned CH_TILT  = 5;

  localparam int unsigned CH_IDX_W   = 3;
  localparam int unsigned EVT_CODE_W = CH_IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_DONE = 2'd2
  } btn_state_t;

  // Event code layout: {long flag, channel index}
  function automatic logic [EVT_CODE_W-1:0] evt_code(input logic is_long,
                                                      input logic [CH_IDX_W-1:0] ch);
    return {is_long, ch};
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Encoded button-event handshake between input_conditioner (master) and its
// consumer (slave).
interface input_conditioner_if;
  import tamagotchi_pkg::*;

  logic                  evt_valid_o;
  logic [EVT_CODE_W-1:0] evt_code_o;
  logic                  evt_ack_i;

  modport master (output evt_valid_o, output evt_code_o, input evt_ack_i);
  modport slave  (input evt_valid_o, input evt_code_o, output evt_ack_i);

endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// One input channel: 2-flop synchroniser, polarity fix, debounce and press FSM.
// Long-press detection exists only when INPUT_COND_LONGPRESS_EN is defined.
module debounce_ch
  import tamagotchi_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned LONG_CYCLES = 150000000,
  parameter bit          ACT_LOW     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic long_pulse
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1, sync2, cond;
  logic [DW-1:0] deb_cnt;
  btn_state_t    state, state_nxt;
  logic          press_nxt;

  // Synchronisers reset to the released raw level so a reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= ACT_LOW;
      sync2 <= ACT_LOW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign cond = sync2 ^ ACT_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (cond == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      level   <= cond;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

`ifdef INPUT_COND_LONGPRESS_EN
  localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_nxt;

  // Saturates at HOLD_LAST and stays there through LONG_DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_nxt;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    press_nxt = 1'b0;
`ifdef INPUT_COND_LONGPRESS_EN
    long_nxt  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (level) begin
          state_nxt = ST_HELD;
          press_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (!level) begin
          state_nxt = ST_IDLE;
`ifdef INPUT_COND_LONGPRESS_EN
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_LONG_DONE;
          long_nxt  = 1'b1;
`endif
        end
      end
`ifdef INPUT_COND_LONGPRESS_EN
      ST_LONG_DONE: begin
        if (!level) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/input_conditioner.sv
// Button/sensor front end: per-channel debounce plus a pending-event queue with
// fixed priority (long before press, low channel first). Option: INPUT_COND_LONGPRESS_EN.
module input_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int unsigned     N_CH         = 6,
  parameter int unsigned     DEB_CYCLES   = 1000000,
  parameter int unsigned     LONG_CYCLES  = 150000000,
  parameter logic [N_CH-1:0] ACT_LOW_MASK = 6'b001111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     raw_i,
  output logic [N_CH-1:0]     level_o,
  output logic [N_CH-1:0]     press_o,
  output logic [N_CH-1:0]     long_o,
  input_conditioner_if.master evt
);

  logic [N_CH-1:0]       pend_press, press_clr;
  logic [EVT_CODE_W-1:0] code;
  logic                  found;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACT_LOW    (ACT_LOW_MASK[g])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw_i[g]),
      .level     (level_o[g]),
      .press     (press_o[g]),
      .long_pulse(long_o[g])
    );
  end

`ifdef INPUT_COND_LONGPRESS_EN
  logic [N_CH-1:0] pend_long, long_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_long <= '0;
    end else begin
      pend_long <= (pend_long & ~long_clr) | long_o;
    end
  end
`endif

  // Set wins over a same-cycle ack so a fresh event on the acked bit survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_press <= '0;
    end else begin
      pend_press <= (pend_press & ~press_clr) | press_o;
    end
  end

  always_comb begin
    found     = 1'b0;
    code      = '0;
    press_clr = '0;
`ifdef INPUT_COND_LONGPRESS_EN
    long_clr  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && pend_long[i]) begin
        found       = 1'b1;
        code        = evt_code(1'b1, CH_IDX_W'(i));
        long_clr[i] = evt.evt_ack_i;
      end
    end
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && pend_press[i]) begin
        found        = 1'b1;
        code         = evt_code(1'b0, CH_IDX_W'(i));
        press_clr[i] = evt.evt_ack_i;
      end
    end
  end

  assign evt.evt_valid_o = found;
  assign evt.evt_code_o  = code;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEB_CYCLES=4, LONG_CYCLES=20:
// directed scenarios followed by random button traffic against a timing model.
module tb_input_conditioner;
  import tamagotchi_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam logic [5:0]  MASK = 6'b001111;
`ifdef INPUT_COND_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] raw;
  logic [5:0] level, press, long_p;
  logic       ack;
  int         tests = 0;
  int         fails = 0;

  input_conditioner_if evt_if();
  assign evt_if.evt_ack_i = ack;

  input_conditioner #(
    .N_CH        (6),
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .ACT_LOW_MASK(MASK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (raw),
    .level_o(level),
    .press_o(press),
    .long_o (long_p),
    .evt    (evt_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: level accepted after DEB disagreeing samples; press one cycle
  // after level rises, long LONG cycles after the press; pending set/ack queue.
  logic [5:0]  m_s1, m_s2, m_lvl, m_press, m_long, m_pp, m_pl;
  int unsigned m_run[6];
  int unsigned m_age[6];

  function automatic logic [4:0] pick(input logic [5:0] pp, input logic [5:0] pl);
    for (int i = 0; i < 6; i++)
      if (LP_EN && pl[i]) return {1'b1, 1'b1, 3'(i)};
    for (int i = 0; i < 6; i++)
      if (pp[i]) return {1'b1, 1'b0, 3'(i)};
    return 5'b0;
  endfunction

  function automatic logic [5:0] pv(input logic [5:0] pressed);
    return pressed ^ MASK;
  endfunction

  task automatic model_reset();
    m_s1 = MASK; m_s2 = MASK;
    m_lvl = '0; m_press = '0; m_long = '0; m_pp = '0; m_pl = '0;
    for (int i = 0; i < 6; i++) begin m_run[i] = 0; m_age[i] = 0; end
  endtask

  task automatic model_edge(input logic [5:0] r, input logic a);
    logic [4:0] sel;
    logic [5:0] np, nl;
    logic       c, old;
    sel = pick(m_pp, m_pl);
    if (a && sel[4]) begin
      if (sel[3]) m_pl[sel[2:0]] = 1'b0;
      else        m_pp[sel[2:0]] = 1'b0;
    end
    m_pp = m_pp | m_press;
    if (LP_EN) m_pl = m_pl | m_long;
    for (int i = 0; i < 6; i++) begin
      np[i] = m_lvl[i] && (m_age[i] == 0);
      nl[i] = LP_EN && m_lvl[i] && (m_age[i] == LONG);
    end
    for (int i = 0; i < 6; i++) begin
      c   = m_s2[i] ^ MASK[i];
      old = m_lvl[i];
      if (c != old) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_lvl[i] = c; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
      if (m_lvl[i] && !old)                 m_age[i] = 0;
      else if (m_lvl[i] && m_age[i] <= LONG) m_age[i]++;
    end
    m_press = np; m_long = nl;
    m_s2 = m_s1; m_s1 = r;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] s;
    s = pick(m_pp, m_pl);
    chk("level", level, m_lvl);
    chk("press", press, m_press);
    chk("long", long_p, m_long);
    chk("evt_valid", evt_if.evt_valid_o, s[4]);
    chk("evt_code", evt_if.evt_code_o, s[3:0]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_press"}, press, 0);
    chk({tag, "_long"}, long_p, 0);
    chk({tag, "_valid"}, evt_if.evt_valid_o, 0);
    chk({tag, "_code"}, evt_if.evt_code_o, 0);
  endtask

  // Called at a negedge; returns at the next negedge after checking
  task automatic step(input logic [5:0] r, input logic a);
    raw = r;
    ack = a;
    model_edge(r, a);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(pv(6'b0), 1'b0);
  endtask

  task automatic drain();
    logic [4:0] s;
    for (int i = 0; i < 16; i++) begin
      s = pick(m_pp, m_pl);
      if (!s[4]) break;
      step(pv(6'b0), 1'b1);
    end
    chk("drain_empty", evt_if.evt_valid_o, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          first, cnt, drops;
    logic [5:0]  p;
    logic [3:0]  code_a, code_b;
    logic        v_end;

    raw = MASK;
    ack = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // ch0 active-low held low for 10 cycles
    first = 0; cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step(pv(6'b000001), 1'b0);
      if (press[0]) begin cnt++; if (first == 0) first = i; end
    end
    chk("r030_press_step", first, 7);
    chk("r030_press_count", cnt, 1);
    chk("r030_level", level[0], 1);
    chk("r030_code", evt_if.evt_code_o, 4'h0);
    idle(10); drain();

    // ch3 bouncing every 2 cycles, then stable
    cnt = 0; p = '0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) p = p ^ 6'b001000;
      step(pv(p), 1'b0);
      if (press[3]) cnt++;
    end
    for (int i = 0; i < 12; i++) begin
      step(pv(6'b001000), 1'b0);
      if (press[3]) cnt++;
    end
    chk("r031_press_count", cnt, 1);
    idle(10); drain();

    // ch2 held 30 cycles
    cnt = 0; code_a = '0;
    for (int i = 1; i <= 30; i++) begin
      step(pv(6'b000100), 1'b0);
      if (long_p[2]) cnt++;
      if (i == 10) code_a = evt_if.evt_code_o;
    end
    chk("r032_code_press", code_a, 4'h2);
    chk("r032_code_late", evt_if.evt_code_o, LP_EN ? 4'hA : 4'h2);
    chk("r032_long_count", cnt, LP_EN ? 1 : 0);
    idle(10); drain();

    // ch1 and ch4 pressed together, ack held high
    code_a = '0; code_b = '0; v_end = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(pv(6'b010010), 1'b1);
      if (i == 8) code_a = evt_if.evt_code_o;
      if (i == 9) code_b = evt_if.evt_code_o;
      if (i == 10) v_end = evt_if.evt_valid_o;
    end
    chk("r033_first", code_a, 4'h1);
    chk("r033_second", code_b, 4'h4);
    chk("r033_drop", v_end, 0);
    idle(10); drain();

    // Second ch0 press while the first is still pending
    drops = 0; cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      step((i <= 10 || i > 20) ? pv(6'b000001) : pv(6'b0), 1'b0);
      if (press[0]) cnt++;
      if (i >= 8 && (!evt_if.evt_valid_o || evt_if.evt_code_o != 4'h0)) drops++;
    end
    chk("r034_presses", cnt, 2);
    chk("r034_glitch", drops, 0);
    step(pv(6'b000001), 1'b1);
    chk("r034_single", evt_if.evt_valid_o, 0);
    idle(10); drain();

    // Reset in the middle of a ch5 hold, input still held afterwards
    for (int i = 0; i < 10; i++) step(pv(6'b100000), 1'b0);
    mid_reset("r035");
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(pv(6'b100000), 1'b0);
      if (press[5] && first == 0) first = i;
    end
    chk("r035_press_step", first, 7);
    idle(10); drain();

    // Random traffic with glitches and sporadic acks
    p = '0;
    for (int n = 0; n < 1500; n++) begin
      logic [5:0] g;
      g = '0;
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 19) == 0) p[i] = ~p[i];
        if ($urandom_range(0, 39) == 0) g[i] = 1'b1;
      end
      if (n == 750) mid_reset("rand_rst");
      step(pv(p) ^ g, ($urandom_range(0, 2) == 0));
    end
    idle(12); drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
